// File: rtl/ghost_motion_ctrl_if.sv
// Bus between a ghost behaviour block and its motion controller.
// The behaviour side (master) proposes moves and supplies game inputs; the
// controller (slave) owns and returns the committed tile position.
interface ghost_motion_ctrl_if;
    logic       frame_tick;
    logic       enable;
    logic       frightened;
    logic [9:0] nextPos;
    logic [9:0] pacPos;
    logic [9:0] currPos;
    logic [1:0] state;
    logic       step_valid;
    logic       pac_caught;
    logic       ghost_eaten;
    logic       illegal_move;

    modport master (
        output frame_tick, enable, frightened, nextPos, pacPos,
        input  currPos, state, step_valid, pac_caught, ghost_eaten, illegal_move
    );

    modport slave (
        input  frame_tick, enable, frightened, nextPos, pacPos,
        output currPos, state, step_valid, pac_caught, ghost_eaten, illegal_move
    );
endinterface

// File: rtl/ghost_motion_ctrl.sv
// Per-ghost motion controller: owns the ghost tile on a 32x32 wrapping maze,
// paces moves from the behaviour block, and runs start delay, collision
// detection and the eaten/respawn sequence.
module ghost_motion_ctrl #(
    parameter logic [9:0]  HOME_POS       = 10'd463,
    parameter int unsigned START_DELAY    = 60,
    parameter int unsigned MOVE_DIV       = 8,
    parameter int unsigned RESPAWN_FRAMES = 120
) (
    input  logic                clk,
    input  logic                reset,
    ghost_motion_ctrl_if.slave  bus
);

    localparam int unsigned POS_W     = 10;
    localparam int unsigned COORD_W   = 5;
    localparam int unsigned DIV_W     = $clog2(2 * MOVE_DIV + 1);
    localparam int unsigned FRAME_MAX = (START_DELAY > RESPAWN_FRAMES) ? START_DELAY : RESPAWN_FRAMES;
    localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_CHASE = 2'b01,
        ST_EATEN = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    state_t             st;
    logic [POS_W-1:0]   curr_pos;
    logic [DIV_W-1:0]   div_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               step_valid;
    logic               pac_caught;
    logic               ghost_eaten;
    logic               illegal_move;

    logic [COORD_W-1:0] cur_row, cur_col, nxt_row, nxt_col;
    logic [COORD_W-1:0] row_inc, row_dec, col_inc, col_dec;
    logic               move_legal;
    logic [DIV_W-1:0]   limit_m1;

    assign cur_row = curr_pos[9:5];
    assign cur_col = curr_pos[4:0];
    assign nxt_row = bus.nextPos[9:5];
    assign nxt_col = bus.nextPos[4:0];

    // Neighbour coordinates wrap naturally in 5 bits (tunnel and row wrap).
    assign row_inc = cur_row + COORD_W'(1);
    assign row_dec = cur_row - COORD_W'(1);
    assign col_inc = cur_col + COORD_W'(1);
    assign col_dec = cur_col - COORD_W'(1);

    // Proposed tile is legal if it is the current tile or one of its 4 neighbours.
    always_comb begin
        move_legal = 1'b0;
        if (bus.nextPos == curr_pos) begin
            move_legal = 1'b1;
        end else if ((nxt_row == cur_row) && ((nxt_col == col_inc) || (nxt_col == col_dec))) begin
            move_legal = 1'b1;
        end else if ((nxt_col == cur_col) && ((nxt_row == row_inc) || (nxt_row == row_dec))) begin
            move_legal = 1'b1;
        end
    end

    // Frightened ghosts move at half rate; >= compare absorbs mid-count rate drops.
    assign limit_m1 = bus.frightened ? DIV_W'(2 * MOVE_DIV - 1) : DIV_W'(MOVE_DIV - 1);

    // Motion FSM, pacing counters and one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= ST_WAIT;
            curr_pos     <= HOME_POS;
            div_cnt      <= '0;
            frame_cnt    <= '0;
            step_valid   <= 1'b0;
            pac_caught   <= 1'b0;
            ghost_eaten  <= 1'b0;
            illegal_move <= 1'b0;
        end else begin
            step_valid   <= 1'b0;
            pac_caught   <= 1'b0;
            ghost_eaten  <= 1'b0;
            illegal_move <= 1'b0;
            if (bus.enable) begin
                case (st)
                    ST_WAIT: begin
                        if (bus.frame_tick) begin
                            if (frame_cnt == FRAME_W'(START_DELAY - 1)) begin
                                st        <= ST_CHASE;
                                frame_cnt <= '0;
                                div_cnt   <= '0;
                            end else begin
                                frame_cnt <= frame_cnt + FRAME_W'(1);
                            end
                        end
                    end
                    ST_CHASE: begin
                        // Collision has priority over any step in the same cycle.
                        if (curr_pos == bus.pacPos) begin
                            if (bus.frightened) begin
                                ghost_eaten <= 1'b1;
                                curr_pos    <= HOME_POS;
                                st          <= ST_EATEN;
                                frame_cnt   <= '0;
                                div_cnt     <= '0;
                            end else begin
                                pac_caught <= 1'b1;
                                st         <= ST_HALT;
                            end
                        end else if (bus.frame_tick) begin
                            if (div_cnt >= limit_m1) begin
                                div_cnt <= '0;
                                if (move_legal) begin
                                    curr_pos   <= bus.nextPos;
                                    step_valid <= 1'b1;
                                end else begin
                                    illegal_move <= 1'b1;
                                end
                            end else begin
                                div_cnt <= div_cnt + DIV_W'(1);
                            end
                        end
                    end
                    ST_EATEN: begin
                        if (bus.frame_tick) begin
                            if (frame_cnt == FRAME_W'(RESPAWN_FRAMES - 1)) begin
                                st        <= ST_CHASE;
                                frame_cnt <= '0;
                                div_cnt   <= '0;
                            end else begin
                                frame_cnt <= frame_cnt + FRAME_W'(1);
                            end
                        end
                    end
                    default: begin
                        // HALT: frozen until reset.
                    end
                endcase
            end
        end
    end

    assign bus.currPos      = curr_pos;
    assign bus.state        = st;
    assign bus.step_valid   = step_valid;
    assign bus.pac_caught   = pac_caught;
    assign bus.ghost_eaten  = ghost_eaten;
    assign bus.illegal_move = illegal_move;

endmodule
